// File: rtl/ibex_rf_ctx_engine_if.sv
// Register-file port and save/restore stream bundle for ibex_rf_ctx_engine.
// master = the engine; slave = register file plus the stream partner.
interface ibex_rf_ctx_engine_if #(
  parameter int unsigned DataWidth = 32
) ();

  // Register file ports (asynchronous read, write on the rising edge)
  logic [4:0]           rf_raddr_o;
  logic [DataWidth-1:0] rf_rdata_i;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;

  // Save stream out of the engine
  logic                 sv_valid_o;
  logic                 sv_ready_i;
  logic [DataWidth-1:0] sv_data_o;
  logic                 sv_last_o;

  // Restore stream into the engine
  logic                 rs_valid_i;
  logic                 rs_ready_o;
  logic [DataWidth-1:0] rs_data_i;

  modport master (
    output rf_raddr_o, input rf_rdata_i,
    output rf_waddr_o, output rf_wdata_o, output rf_we_o,
    output sv_valid_o, input sv_ready_i, output sv_data_o, output sv_last_o,
    input rs_valid_i, output rs_ready_o, input rs_data_i
  );

  modport slave (
    input rf_raddr_o, output rf_rdata_i,
    input rf_waddr_o, input rf_wdata_o, input rf_we_o,
    input sv_valid_o, output sv_ready_i, input sv_data_o, input sv_last_o,
    output rs_valid_i, input rs_ready_o, output rs_data_i
  );

endinterface

// File: rtl/ibex_rf_ctx_engine.sv
// Register-file context save/restore engine: streams x1..xLAST out, or writes them back.
// Optional checksum over transferred words: define IBEX_RF_CTX_CHECKSUM_EN.
module ibex_rf_ctx_engine #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] csum_o,
  output logic [1:0]           dbg_state_o,
  ibex_rf_ctx_engine_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [5:0] LAST = RV32E ? 6'd15 : 6'd31;

  state_e               state_q;
  logic [5:0]           rd_ptr_q;
  logic [5:0]           wr_ptr_q;
  logic                 sv_valid_q;
  logic                 sv_last_q;
  logic [DataWidth-1:0] sv_data_q;
  logic                 done_q;

  logic sv_hs;
  logic sv_load;
  logic rs_ready;
  logic rs_hs;

  // Valid/ready: a word moves when valid && ready on a rising edge. Once the
  // engine raises sv_valid it holds valid and data until that edge; only
  // abort may withdraw it. The restore side writes in the handshake cycle.
  always_comb begin
    sv_hs    = sv_valid_q && bus.sv_ready_i;
    sv_load  = (state_q == SAVE) && (!sv_valid_q || bus.sv_ready_i) && (rd_ptr_q <= LAST);
    rs_ready = (state_q == RESTORE) && !abort_i;
    rs_hs    = rs_ready && bus.rs_valid_i;
  end

  // Past LAST the read address returns to 0 so bit 4 never rises on RV32E.
  assign bus.rf_raddr_o = ((state_q == SAVE) && (rd_ptr_q <= LAST)) ? rd_ptr_q[4:0] : 5'd0;
  assign bus.rf_we_o    = rs_hs;
  assign bus.rf_waddr_o = rs_hs ? wr_ptr_q[4:0] : 5'd0;
  assign bus.rf_wdata_o = rs_hs ? bus.rs_data_i : '0;
  assign bus.rs_ready_o = rs_ready;
  assign bus.sv_valid_o = sv_valid_q;
  assign bus.sv_data_o  = sv_data_q;
  assign bus.sv_last_o  = sv_last_q;

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rd_ptr_q   <= 6'd0;
      wr_ptr_q   <= 6'd0;
      sv_valid_q <= 1'b0;
      sv_last_q  <= 1'b0;
      sv_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (save_req_i) begin
            state_q  <= SAVE;
            rd_ptr_q <= 6'd1;
          end else if (restore_req_i) begin
            state_q  <= RESTORE;
            wr_ptr_q <= 6'd1;
          end
        end

        SAVE: begin
          if (abort_i) begin
            state_q    <= IDLE;
            rd_ptr_q   <= 6'd0;
            sv_valid_q <= 1'b0;
            sv_last_q  <= 1'b0;
            sv_data_q  <= '0;
          end else if (sv_hs && sv_last_q) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            rd_ptr_q   <= 6'd0;
            sv_valid_q <= 1'b0;
            sv_last_q  <= 1'b0;
            sv_data_q  <= '0;
          end else if (sv_load) begin
            sv_valid_q <= 1'b1;
            sv_data_q  <= bus.rf_rdata_i;
            sv_last_q  <= (rd_ptr_q == LAST);
            rd_ptr_q   <= rd_ptr_q + 6'd1;
          end else if (sv_hs) begin
            sv_valid_q <= 1'b0;
          end
        end

        RESTORE: begin
          if (abort_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= 6'd0;
          end else if (rs_hs) begin
            if (wr_ptr_q == LAST) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              wr_ptr_q <= 6'd0;
            end else begin
              wr_ptr_q <= wr_ptr_q + 6'd1;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IBEX_RF_CTX_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q;

  // Rotate-left-by-one then XOR the word; survives DONE/abort until the next start.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && (save_req_i || restore_req_i)) begin
      csum_q <= '0;
    end else if ((state_q == SAVE) && sv_hs) begin
      csum_q <= {csum_q[DataWidth-2:0], csum_q[DataWidth-1]} ^ sv_data_q;
    end else if (rs_hs) begin
      csum_q <= {csum_q[DataWidth-2:0], csum_q[DataWidth-1]} ^ bus.rs_data_i;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = '0;
`endif

endmodule
